// File: rtl/pll_reset_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// pll_reset_sequencer : PLL reset/lock qualification and staggered clk resets
// Rev 1.0
// ============================================================================
module pll_reset_sequencer #(
  parameter int PLL_RST_CYCLES     = 16,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int LOCK_TIMEOUT       = 65536,
  parameter int STAGGER_CYCLES     = 8
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic       restart,
  output logic       pll_rst,
  output logic [2:0] clk_rst,
  output logic       ready,
  output logic       restart_ack,
  output logic       timeout_err,
  output logic [7:0] relock_cnt
);

  localparam int RST_W = $clog2(PLL_RST_CYCLES) + 1;
  localparam int TO_W  = $clog2(LOCK_TIMEOUT) + 1;
  localparam int STB_W = $clog2(LOCK_STABLE_CYCLES) + 1;
  localparam int STG_W = $clog2(2 * STAGGER_CYCLES) + 1;

  localparam logic [RST_W-1:0] C_RST_LAST = RST_W'(PLL_RST_CYCLES - 1);
  localparam logic [TO_W-1:0]  C_TO_LAST  = TO_W'(LOCK_TIMEOUT - 1);
  localparam logic [STB_W-1:0] C_STB_LAST = STB_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [STG_W-1:0] C_STG_LAST = STG_W'(2 * STAGGER_CYCLES - 1);
  localparam logic [STG_W-1:0] C_STG_HALF = STG_W'(STAGGER_CYCLES);

  typedef enum logic [2:0] {
    S_RESET_PLL = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RELEASE   = 3'd3,
    S_RUN       = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic               lock_meta_q, lock_s_q;
  logic [RST_W-1:0]   rst_cnt_q, rst_cnt_d;
  logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
  logic [STB_W-1:0]   stb_cnt_q, stb_cnt_d;
  logic [STG_W-1:0]   stg_cnt_q, stg_cnt_d;
  logic               pll_rst_q, pll_rst_d;
  logic [2:0]         clk_rst_q, clk_rst_d;
  logic               ready_q, ready_d;
  logic               restart_ack_q, restart_ack_d;
  logic               timeout_err_q, timeout_err_d;
  logic [7:0]         relock_cnt_q, relock_cnt_d;

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_RESET_PLL;
      lock_meta_q   <= 1'b0;
      lock_s_q      <= 1'b0;
      rst_cnt_q     <= '0;
      to_cnt_q      <= '0;
      stb_cnt_q     <= '0;
      stg_cnt_q     <= '0;
      pll_rst_q     <= 1'b1;
      clk_rst_q     <= 3'b111;
      ready_q       <= 1'b0;
      restart_ack_q <= 1'b0;
      timeout_err_q <= 1'b0;
      relock_cnt_q  <= 8'd0;
    end else begin
      state_q       <= state_d;
      lock_meta_q   <= pll_locked;
      lock_s_q      <= lock_meta_q;
      rst_cnt_q     <= rst_cnt_d;
      to_cnt_q      <= to_cnt_d;
      stb_cnt_q     <= stb_cnt_d;
      stg_cnt_q     <= stg_cnt_d;
      pll_rst_q     <= pll_rst_d;
      clk_rst_q     <= clk_rst_d;
      ready_q       <= ready_d;
      restart_ack_q <= restart_ack_d;
      timeout_err_q <= timeout_err_d;
      relock_cnt_q  <= relock_cnt_d;
    end
  end

  // Each counter rests at zero outside its own state, so every entry starts fresh.
  always_comb begin
    state_d       = state_q;
    rst_cnt_d     = '0;
    to_cnt_d      = '0;
    stb_cnt_d     = '0;
    stg_cnt_d     = '0;
    restart_ack_d = 1'b0;
    timeout_err_d = timeout_err_q;
    relock_cnt_d  = relock_cnt_q;

    case (state_q)
      S_RESET_PLL: begin
        if (rst_cnt_q == C_RST_LAST) state_d = S_WAIT_LOCK;
        else                         rst_cnt_d = rst_cnt_q + 1'b1;
      end
      S_WAIT_LOCK: begin
        if (lock_s_q) begin
          state_d = S_STABLE;
        end else if (to_cnt_q == C_TO_LAST) begin
          timeout_err_d = 1'b1;
          state_d       = S_RESET_PLL;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      S_STABLE: begin
        if (!lock_s_q)                   state_d = S_WAIT_LOCK;
        else if (stb_cnt_q == C_STB_LAST) state_d = S_RELEASE;
        else                             stb_cnt_d = stb_cnt_q + 1'b1;
      end
      S_RELEASE, S_RUN: begin
        // Lock loss outranks a coincident restart request.
        if (!lock_s_q) begin
          state_d = S_RESET_PLL;
          if (relock_cnt_q != 8'hFF) relock_cnt_d = relock_cnt_q + 8'd1;
        end else if (state_q == S_RELEASE) begin
          if (stg_cnt_q == C_STG_LAST) state_d = S_RUN;
          else                         stg_cnt_d = stg_cnt_q + 1'b1;
        end else if (restart) begin
          restart_ack_d = 1'b1;
          state_d       = S_RESET_PLL;
        end
      end
      default: state_d = S_RESET_PLL;
    endcase

    pll_rst_d = (state_d == S_RESET_PLL);
    ready_d   = (state_d == S_RUN);
    case (state_d)
      S_RELEASE: clk_rst_d = (stg_cnt_d < C_STG_HALF) ? 3'b110 : 3'b100;
      S_RUN:     clk_rst_d = 3'b000;
      default:   clk_rst_d = 3'b111;
    endcase
  end

  assign pll_rst     = pll_rst_q;
  assign clk_rst     = clk_rst_q;
  assign ready       = ready_q;
  assign restart_ack = restart_ack_q;
  assign timeout_err = timeout_err_q;
  assign relock_cnt  = relock_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pll_reset_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// Directed bench for pll_reset_sequencer: clk_rst transitions are predicted into
// a queue with their expected cycle spacing and checked as they occur.
module tb_pll_reset_sequencer;

  logic       refclk = 1'b0;
  logic       rst_n;
  logic       pll_locked;
  logic       restart;
  logic       pll_rst;
  logic [2:0] clk_rst;
  logic       ready;
  logic       restart_ack;
  logic       timeout_err;
  logic [7:0] relock_cnt;

  pll_reset_sequencer #(
    .PLL_RST_CYCLES    (4),
    .LOCK_STABLE_CYCLES(8),
    .LOCK_TIMEOUT      (32),
    .STAGGER_CYCLES    (2)
  ) dut (
    .refclk     (refclk),
    .rst_n      (rst_n),
    .pll_locked (pll_locked),
    .restart    (restart),
    .pll_rst    (pll_rst),
    .clk_rst    (clk_rst),
    .ready      (ready),
    .restart_ack(restart_ack),
    .timeout_err(timeout_err),
    .relock_cnt (relock_cnt)
  );

  always #5 refclk = ~refclk;

  typedef struct {
    logic [2:0] clk_rst;
    logic       rdy;
    int         gap;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  int         n_checks = 0;
  int         n_fail   = 0;
  int         cyc      = 0;
  int         mark_cyc = 0;
  int         ack_cnt  = 0;
  bit         sb_en    = 1'b0;
  logic [2:0] prev_clk_rst = 3'b111;

  always @(posedge refclk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [2:0] c, input logic r, input int g);
    exp_t e;
    e.clk_rst = c;
    e.rdy     = r;
    e.gap     = g;
    exp_q.push_back(e);
  endtask

  always @(negedge refclk) begin
    if (restart_ack === 1'b1) ack_cnt++;
    if (sb_en && (clk_rst !== prev_clk_rst)) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_change", exp_q.size(), 1);
      end else begin
        mon_e = exp_q.pop_front();
        check("sb_clk_rst", {29'd0, clk_rst}, {29'd0, mon_e.clk_rst});
        check("sb_ready", {31'd0, ready}, {31'd0, mon_e.rdy});
        check("sb_gap", cyc - mark_cyc, mon_e.gap);
      end
      mark_cyc = cyc;
    end
    prev_clk_rst = clk_rst;
  end

  task automatic tick();
    @(negedge refclk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) tick();
  endtask

  task automatic wait_ready(input int bound);
    int n = 0;
    while (ready !== 1'b1 && n < bound) begin
      tick();
      n++;
    end
    check("wait_ready", {31'd0, ready}, 1);
  endtask

  task automatic wait_sb_empty(input int bound);
    int n = 0;
    while (exp_q.size() != 0 && n < bound) begin
      tick();
      n++;
    end
    check("wait_sb_empty", exp_q.size(), 0);
  endtask

  task automatic mark();
    mark_cyc = cyc;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: cycle %0d reached without completion", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c, k, n;

    rst_n      = 1'b0;
    pll_locked = 1'b0;
    restart    = 1'b0;
    ticks(3);
    check("rst_pll_rst", {31'd0, pll_rst}, 1);
    check("rst_clk_rst", {29'd0, clk_rst}, 3'b111);
    check("rst_ready", {31'd0, ready}, 0);
    check("rst_ack", {31'd0, restart_ack}, 0);
    check("rst_timeout", {31'd0, timeout_err}, 0);
    check("rst_relock", {24'd0, relock_cnt}, 0);

    // Normal bring-up
    sb_en = 1'b1;
    rst_n = 1'b1;
    c = cyc;
    n = 0;
    while (pll_rst === 1'b1 && n < 100) begin
      n++;
      tick();
    end
    check("bringup_pll_rst_len", n, 4);
    wait_until(c + 10);
    pll_locked = 1'b1;
    mark();
    push(3'b110, 1'b0, 11);
    push(3'b100, 1'b0, 2);
    push(3'b000, 1'b1, 2);
    wait_ready(40);
    wait_sb_empty(5);
    check("bringup_relock", {24'd0, relock_cnt}, 0);
    check("bringup_timeout", {31'd0, timeout_err}, 0);
    check("bringup_pll_rst", {31'd0, pll_rst}, 0);

    // Lock loss in RUN, then full re-sequence
    ticks(3);
    k = cyc;
    pll_locked = 1'b0;
    mark();
    push(3'b111, 1'b0, 3);
    ticks(3);
    check("lossrun_ready", {31'd0, ready}, 0);
    check("lossrun_clk_rst", {29'd0, clk_rst}, 3'b111);
    ticks(3);
    check("lossrun_relock", {24'd0, relock_cnt}, 1);
    check("lossrun_pll_rst", {31'd0, pll_rst}, 1);
    pll_locked = 1'b1;
    mark();
    push(3'b110, 1'b0, 11);
    push(3'b100, 1'b0, 2);
    push(3'b000, 1'b1, 2);
    wait_ready(40);
    wait_sb_empty(5);

    // Restart held for 50 cycles
    ticks(3);
    check("restart_ack_pre", ack_cnt, 0);
    k = cyc;
    restart = 1'b1;
    mark();
    for (int i = 0; i < 3; i++) begin
      push(3'b111, 1'b0, 1);
      push(3'b110, 1'b0, 13);
      push(3'b100, 1'b0, 2);
      push(3'b000, 1'b1, 2);
    end
    tick();
    wait_ready(40);
    check("restart_one_ack_before_run", ack_cnt, 1);
    wait_until(k + 50);
    restart = 1'b0;
    wait_sb_empty(40);
    ticks(3);
    check("restart_total_acks", ack_cnt, 3);
    check("restart_relock", {24'd0, relock_cnt}, 1);
    check("restart_ready", {31'd0, ready}, 1);

    // Lock loss and restart in the same RUN cycle; restart then held in RESET_PLL
    ticks(3);
    pll_locked = 1'b0;
    mark();
    push(3'b111, 1'b0, 3);
    ticks(2);
    restart = 1'b1;
    ticks(4);
    restart = 1'b0;
    check("simul_no_ack", ack_cnt, 3);
    check("simul_relock", {24'd0, relock_cnt}, 2);
    check("simul_pll_rst", {31'd0, pll_rst}, 1);
    pll_locked = 1'b1;
    mark();
    push(3'b110, 1'b0, 11);
    push(3'b100, 1'b0, 2);
    push(3'b000, 1'b1, 2);
    wait_ready(40);
    wait_sb_empty(5);

    // Reset asserted during RELEASE acts without a clock edge
    ticks(3);
    pll_locked = 1'b0;
    mark();
    push(3'b111, 1'b0, 3);
    ticks(6);
    pll_locked = 1'b1;
    mark();
    push(3'b110, 1'b0, 11);
    wait_sb_empty(40);
    sb_en = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("midrst_pll_rst", {31'd0, pll_rst}, 1);
    check("midrst_clk_rst", {29'd0, clk_rst}, 3'b111);
    check("midrst_ready", {31'd0, ready}, 0);
    check("midrst_ack", {31'd0, restart_ack}, 0);
    check("midrst_timeout", {31'd0, timeout_err}, 0);
    check("midrst_relock", {24'd0, relock_cnt}, 0);

    // Lock glitch during STABLE
    pll_locked = 1'b0;
    ticks(2);
    sb_en = 1'b1;
    rst_n = 1'b1;
    c = cyc;
    wait_until(c + 6);
    pll_locked = 1'b1;
    wait_until(c + 10);
    pll_locked = 1'b0;
    wait_until(c + 13);
    pll_locked = 1'b1;
    mark();
    push(3'b110, 1'b0, 11);
    push(3'b100, 1'b0, 2);
    push(3'b000, 1'b1, 2);
    wait_ready(40);
    wait_sb_empty(5);
    check("glitch_relock", {24'd0, relock_cnt}, 0);
    check("glitch_timeout", {31'd0, timeout_err}, 0);

    // Lock timeout with pll_locked held low
    sb_en = 1'b0;
    rst_n = 1'b0;
    pll_locked = 1'b0;
    ticks(2);
    sb_en = 1'b1;
    rst_n = 1'b1;
    c = cyc;
    wait_until(c + 35);
    check("timeout_err_before", {31'd0, timeout_err}, 0);
    check("timeout_pll_rst_before", {31'd0, pll_rst}, 0);
    tick();
    check("timeout_err_set", {31'd0, timeout_err}, 1);
    check("timeout_pll_rst_set", {31'd0, pll_rst}, 1);
    n = 0;
    while (pll_rst === 1'b1 && n < 100) begin
      n++;
      tick();
    end
    check("timeout_pll_rst_len", n, 4);
    n = 0;
    while (pll_rst !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    check("timeout_repeat_gap", n, 32);
    check("timeout_err_sticky", {31'd0, timeout_err}, 1);
    check("timeout_clk_rst", {29'd0, clk_rst}, 3'b111);
    check("final_sb_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pll_reset_sequencer.md
PLL_RESET_SEQUENCER -- requirements
Module: pll_reset_sequencer

Interface
REQ-001 Parameter PLL_RST_CYCLES, default 16: refclk cycles `pll_rst` is held high per reset attempt.
REQ-002 Parameter LOCK_STABLE_CYCLES, default 1024: consecutive synchronized-lock cycles required before release.
REQ-003 Parameter LOCK_TIMEOUT, default 65536: refclk cycles allowed in WAIT_LOCK before the PLL is reset again.
REQ-004 Parameter STAGGER_CYCLES, default 8: refclk cycles between successive reset releases.
REQ-005 `refclk`, input, 1: the single clock; all logic is rising-edge in this domain.
REQ-006 `rst_n`, input, 1: asynchronous, active-low reset.
REQ-007 `pll_locked`, input, 1: PLL lock, asynchronous to refclk.
REQ-008 `restart`, input, 1: level request for a PLL reset cycle (e.g. clock-mode change).
REQ-009 `pll_rst`, output, 1: active-high reset to the PLL `rst` pin.
REQ-010 `clk_rst`, output, 3: active-high resets for outclk_0, outclk_1 and outclk_2 consumers (bit n to outclk_n); the consumer re-synchronizes each bit.
REQ-011 `ready`, output, 1: high only in RUN.
REQ-012 `restart_ack`, output, 1: one-cycle pulse when a restart is accepted.
REQ-013 `timeout_err`, output, 1: sticky flag; set on any lock timeout.
REQ-014 `relock_cnt`, output, 8: count of unsolicited lock losses after release; saturates at 255.

Function
REQ-015 `pll_locked` SHALL pass through a 2-flop synchronizer (`lock_s`) before any use; this adds 2 cycles of latency.
REQ-016 The FSM SHALL have the states RESET_PLL, WAIT_LOCK, STABLE, RELEASE and RUN; all outputs are registered.
REQ-017 RESET_PLL: `pll_rst`=1 and `clk_rst`=3'b111; after PLL_RST_CYCLES cycles the FSM goes to WAIT_LOCK.
REQ-018 WAIT_LOCK: `pll_rst`=0. When `lock_s`=1 the FSM goes to STABLE with the stable counter cleared. After LOCK_TIMEOUT cycles with no lock it sets `timeout_err` and goes to RESET_PLL.
REQ-019 STABLE: the counter increments while `lock_s`=1. If `lock_s`=0 the FSM returns to WAIT_LOCK; this is not counted in `relock_cnt` and the timeout counter restarts. When the count reaches LOCK_STABLE_CYCLES the FSM goes to RELEASE.
REQ-020 RELEASE: `clk_rst[0]` clears on entry; `clk_rst[1]` clears STAGGER_CYCLES cycles later; `clk_rst[2]` clears 2*STAGGER_CYCLES cycles after entry, and the FSM enters RUN on that same cycle.
REQ-021 RUN: `ready`=1 and `clk_rst`=0.
REQ-022 If `lock_s`=0 in RELEASE or RUN: `clk_rst`=3'b111 and `ready`=0 on the next edge, the FSM goes to RESET_PLL, and `relock_cnt` increments (saturating).
REQ-023 `restart`=1 SHALL be acted on only in RUN: pulse `restart_ack` for one cycle and go to RESET_PLL. `relock_cnt` is not incremented.
REQ-024 If `restart` stays high, the next restart SHALL NOT be accepted before RUN is re-entered.
REQ-025 If lock loss and `restart` occur in the same RUN cycle, lock loss SHALL take priority: `relock_cnt` increments and no `restart_ack` is generated.
REQ-026 `restart` SHALL be ignored in all states other than RUN; no ack is generated.
REQ-027 All counters SHALL be sized from their parameters (clog2+1 bits) and cleared on every state entry.

Reset
REQ-028 While `rst_n`=0, at any time including mid-sequence, the following SHALL hold asynchronously: state=RESET_PLL, `pll_rst`=1, `clk_rst`=3'b111, `ready`=0, `restart_ack`=0, `timeout_err`=0, `relock_cnt`=0, synchronizer flops=0, all counters=0.
REQ-029 On `rst_n` deassertion, sequencing SHALL begin at REQ-017 on the next refclk edge.

Verification
All scenarios use the bench parameters PLL_RST_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT=32, STAGGER_CYCLES=2.
REQ-030 Normal bring-up:
- Stimulus: release `rst_n`; raise `pll_locked` 10 cycles later.
- Response: `pll_rst` high for 4 cycles; `clk_rst` goes 111 -> 110 -> 100 -> 000 in steps of 2 cycles; `ready`=1 at the 000 step.
REQ-031 Glitch during STABLE:
- Stimulus: drop `pll_locked` for 3 cycles midway through STABLE.
- Response: return to WAIT_LOCK; `relock_cnt`=0; the full 8-cycle stability window restarts.
REQ-032 Timeout:
- Stimulus: hold `pll_locked`=0.
- Response: `timeout_err`=1 after 32 WAIT_LOCK cycles; `pll_rst` re-pulses for 4 cycles; the cycle repeats.
REQ-033 Lock loss in RUN:
- Stimulus: drop `pll_locked` in RUN.
- Response: `clk_rst`=111 and `ready`=0 within 3 cycles of the input edge; `relock_cnt`=1; on relock, a full re-sequence.
REQ-034 Restart:
- Stimulus: `restart` held high for 50 cycles in RUN.
- Response: exactly one `restart_ack` pulse before RUN is re-entered; the simultaneous lock-loss case yields no ack and `relock_cnt`+1.
REQ-035 Mid-sequence reset:
- Stimulus: assert `rst_n`=0 during RELEASE.
- Response: all outputs return to the REQ-028 values immediately, without waiting for a clock edge.
